ecg_pack_enc: RTL

//  Entropy-coding-group (ECG) encoder: the transmit counterpart of the ECG parser. Takes up to
//  7 quantised coefficients per group and emits one left-justified codeword (skip flag, unary

---
 rtl/ecg_pack_enc_if.sv | 29 ++
 rtl/ecg_pack_enc.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ecg_pack_enc_if.sv
// Handshake and data bundle between the quantiser, the ECG encoder and the bit packer.
interface ecg_pack_enc_if #(
    parameter int CNT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_num_sample;
    logic [62:0]      in_coeffs;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_code;
    logic [7:0]       out_numbits;
    logic [6:0]       out_sign_bits;
    logic [6:0]       out_sign_valid;
    logic [CNT_W-1:0] bits_total;
    logic             sat_err;

    modport master (
        output in_valid, in_num_sample, in_coeffs, out_ready,
        input  in_ready, out_valid, out_code, out_numbits,
               out_sign_bits, out_sign_valid, bits_total, sat_err
    );

    modport slave (
        input  in_valid, in_num_sample, in_coeffs, out_ready,
        output in_ready, out_valid, out_code, out_numbits,
               out_sign_bits, out_sign_valid, bits_total, sat_err
    );
endinterface

// File: rtl/ecg_pack_enc.sv
// ECG encoder: clamps a group of up to 7 coefficients, sizes the samples, and emits one
// left-justified codeword through a 2-stage valid/ready pipeline.
module ecg_pack_enc #(
    parameter int ECG_IDX = 0,
    parameter int CNT_W   = 32
) (
    input  logic          clk,
    input  logic          rst,
    ecg_pack_enc_if.slave bus
);
    localparam bit IS_SM = (ECG_IDX < 3);

    logic             r_s1_v;
    logic [2:0]       r_s1_n;
    logic             r_s1_skip;
    logic [3:0]       r_s1_bits;
    logic [6:0][7:0]  r_s1_val;
    logic [6:0]       r_s1_neg;
    logic [6:0]       r_s1_nz;
    logic             r_s2_v;
    logic [127:0]     r_code;
    logic [7:0]       r_numbits;
    logic [6:0]       r_sign_bits;
    logic [6:0]       r_sign_valid;
    logic [CNT_W-1:0] r_bits_total;
    logic             r_sat;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_adv2;
    logic [2:0]       w_n;
    logic [6:0][7:0]  w_val;
    logic [6:0]       w_neg;
    logic [6:0]       w_nz;
    logic [6:0]       w_clip;
    logic [7:0]       w_or;
    logic [3:0]       w_bits;
    logic [127:0]     w_code;
    logic [7:0]       w_numbits;
    logic [6:0]       w_sign_bits;
    logic [6:0]       w_sign_valid;

    assign w_in_ready = ~r_s1_v | ~r_s2_v | bus.out_ready;
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_adv2     = r_s1_v & (~r_s2_v | bus.out_ready);
    assign w_n        = (bus.in_num_sample == 3'd0) ? 3'd1 : bus.in_num_sample;

    // Stage 1: clamp active coefficients and find the common sample width.
    // w_or collects magnitudes (SM) or sign-folded values (2C) so one bit-length gives the max.
    always_comb begin
        logic signed [8:0] v_c;
        logic [8:0]        v_mag;
        logic [3:0]        v_len;
        // NOTE: every variable gets a default before any branch, otherwise a path that skips
        // an assignment infers a latch.
        w_val  = '0;
        w_neg  = '0;
        w_nz   = '0;
        w_clip = '0;
        w_or   = '0;
        v_c    = '0;
        v_mag  = '0;
        v_len  = '0;
        for (int k = 0; k < 7; k++) begin
            if (3'(k) < w_n) begin
                v_c = $signed(bus.in_coeffs[9*k +: 9]);
                if (IS_SM) begin
                    v_mag     = v_c[8] ? 9'(-v_c) : 9'(v_c);
                    w_clip[k] = v_mag[8];
                    w_val[k]  = v_mag[8] ? 8'hFF : v_mag[7:0];
                    w_neg[k]  = v_c[8];
                    w_or      = w_or | w_val[k];
                end else begin
                    if (v_c > 9'sd127) begin
                        w_clip[k] = 1'b1;
                        w_val[k]  = 8'h7F;
                    end else if (v_c < -9'sd128) begin
                        w_clip[k] = 1'b1;
                        w_val[k]  = 8'h80;
                    end else begin
                        w_val[k]  = v_c[7:0];
                    end
                    w_or = w_or | (w_val[k][7] ? ~w_val[k] : w_val[k]);
                end
                w_nz[k] = (w_val[k] != 8'd0);
            end
        end
        for (int b = 0; b < 8; b++) begin
            if (w_or[b]) v_len = 4'(b + 1);
        end
        if (IS_SM) w_bits = (v_len == 4'd0) ? 4'd1 : v_len;
        else       w_bits = v_len + 4'd1;
    end

    // Stage 2: build the codeword right-aligned, then shift it up to bit 127.
    always_comb begin
        logic [127:0] v_acc;
        logic [3:0]   v_pre;
        w_code       = '0;
        w_numbits    = 8'd1;
        w_sign_bits  = '0;
        w_sign_valid = '0;
        v_acc        = '0;
        v_pre        = '0;
        if (r_s1_skip) begin
            w_code[127] = 1'b1;
        end else begin
            v_pre = r_s1_bits - 4'd1;
            v_acc = ((128'd1 << v_pre) - 128'd1) << 1;
            for (int k = 0; k < 7; k++) begin
                if (3'(k) < r_s1_n) begin
                    v_acc = (v_acc << r_s1_bits)
                          | (128'(r_s1_val[k]) & ((128'd1 << r_s1_bits) - 128'd1));
                end
            end
            w_numbits = 8'd2 + 8'(v_pre) + 8'(r_s1_n) * 8'(r_s1_bits);
            w_code    = v_acc << (8'd128 - w_numbits);
            if (IS_SM) begin
                w_sign_bits  = r_s1_neg;
                w_sign_valid = r_s1_nz;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_v       <= 1'b0;
            r_s1_n       <= '0;
            r_s1_skip    <= 1'b0;
            r_s1_bits    <= '0;
            r_s1_val     <= '0;
            r_s1_neg     <= '0;
            r_s1_nz      <= '0;
            r_s2_v       <= 1'b0;
            r_code       <= '0;
            r_numbits    <= '0;
            r_sign_bits  <= '0;
            r_sign_valid <= '0;
            r_bits_total <= '0;
            r_sat        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values; stage 2
            // must see the old stage-1 contents while stage 1 loads the next group.
            if (w_accept) begin
                r_s1_n    <= w_n;
                r_s1_skip <= ~|w_nz;
                r_s1_bits <= w_bits;
                r_s1_val  <= w_val;
                r_s1_neg  <= w_neg;
                r_s1_nz   <= w_nz;
                r_sat     <= r_sat | (|w_clip);
            end
            r_s1_v <= w_accept | (r_s1_v & ~w_adv2);
            if (w_adv2) begin
                r_code       <= w_code;
                r_numbits    <= w_numbits;
                r_sign_bits  <= w_sign_bits;
                r_sign_valid <= w_sign_valid;
            end
            r_s2_v <= w_adv2 | (r_s2_v & ~bus.out_ready);
            if (r_s2_v & bus.out_ready) r_bits_total <= r_bits_total + CNT_W'(r_numbits);
        end
    end

    assign bus.in_ready       = w_in_ready;
    assign bus.out_valid      = r_s2_v;
    assign bus.out_code       = r_code;
    assign bus.out_numbits    = r_numbits;
    assign bus.out_sign_bits  = r_sign_bits;
    assign bus.out_sign_valid = r_sign_valid;
    assign bus.bits_total     = r_bits_total;
    assign bus.sat_err        = r_sat;
endmodule
